ps2_rx: RTL and testbench



---
 rtl/ps2_rx.sv | 181 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the clock/data pair,
// deserialises 11-bit frames and buffers good bytes in a first-word-fall-through FIFO.
module ps2_rx #(
   parameter int unsigned FIFO_BITS      = 3,
   parameter int unsigned FILTER         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 12000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overflow,
   output logic       busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   localparam int unsigned DEPTH = 2 ** FIFO_BITS;

   logic       clk_s1, clk_s2, data_s1, data_s2;
   logic [3:0] filt_cnt_q;
   logic       filt_clk_q;
   logic       filt_hit, fall;

   logic [1:0]  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        par_q, par_d, par_ok_q, par_ok_d;
   logic [15:0] tmo_q, tmo_d;
   logic        push, perr_d, ferr_d, ovf_d;
   logic        perr_q, ferr_q, ovf_q;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_BITS:0] wptr_q, rptr_q;
   logic               empty, full, pop, wr_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk_in;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data_in;
         data_s2 <= data_s1;
      end
   end

   // The filtered clock flips on the FILTER-th consecutive sample that disagrees with it.
   always_comb begin
      filt_hit = (filt_cnt_q == 4'(FILTER - 1));
      fall     = filt_clk_q & ~clk_s2 & filt_hit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_cnt_q <= 4'd0;
         filt_clk_q <= 1'b1;
      end else if (clk_s2 == filt_clk_q) begin
         filt_cnt_q <= 4'd0;
      end else if (filt_hit) begin
         filt_cnt_q <= 4'd0;
         filt_clk_q <= clk_s2;
      end else begin
         filt_cnt_q <= filt_cnt_q + 4'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      par_ok_d  = par_ok_q;
      push      = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      tmo_d     = (state_q == IDLE || fall) ? 16'd0 : tmo_q + 16'd1;
      if (state_q != IDLE && !fall && (tmo_q + 16'd1 == 16'(TIMEOUT_CYCLES))) begin
         state_d = IDLE;
         ferr_d  = 1'b1;
         tmo_d   = 16'd0;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               if (!data_s2) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
                  par_d     = 1'b0;
               end
            end
            DATA: begin
               shreg_d   = {data_s2, shreg_q[7:1]};
               par_d     = par_q ^ data_s2;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_ok_d = par_q ^ data_s2;
               state_d  = STOP;
            end
            STOP: begin
               // A bad stop bit outranks a parity error.
               if (!data_s2)       ferr_d = 1'b1;
               else if (!par_ok_q) perr_d = 1'b1;
               else                push   = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= 3'd0;
         shreg_q   <= 8'd0;
         par_q     <= 1'b0;
         par_ok_q  <= 1'b0;
         tmo_q     <= 16'd0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         par_ok_q  <= par_ok_d;
         tmo_q     <= tmo_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[FIFO_BITS] != rptr_q[FIFO_BITS]) &&
              (wptr_q[FIFO_BITS-1:0] == rptr_q[FIFO_BITS-1:0]);
      pop   = !empty && rx_ready;
      // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
      wr_en = push && (!full || pop);
      ovf_d = push && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr_q[FIFO_BITS-1:0]] <= shreg_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (pop)   rptr_q <= rptr_q + 1'b1;
      end
   end

   always_comb begin
      rx_valid   = !empty;
      rx_data    = empty ? 8'h00 : mem[rptr_q[FIFO_BITS-1:0]];
      parity_err = perr_q;
      frame_err  = ferr_q;
      overflow   = ovf_q;
      busy       = (state_q != IDLE);
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frames are bit-banged on the PS/2 lines and good
// bytes are scoreboarded against FIFO pops; error pulses are counted per cycle.
module tb_ps2_rx;

   localparam int unsigned FIFO_BITS = 3;
   localparam int unsigned FILTER    = 4;
   localparam int unsigned TMO       = 300;
   localparam int unsigned HALF      = 40;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk_in = 1'b1;
   logic       ps2_data_in = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       parity_err, frame_err, overflow, busy;

   int n_cmp = 0;
   int n_fail = 0;
   int n_par = 0;
   int n_frm = 0;
   int n_ovf = 0;
   int cyc = 0;
   int last_fall_cyc = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   ps2_rx #(
      .FIFO_BITS      (FIFO_BITS),
      .FILTER         (FILTER),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Scoreboard: every accepted pop must match the oldest expected byte.
   always @(negedge clk) begin
      if (reset_n) begin
         if (parity_err) n_par++;
         if (frame_err)  n_frm++;
         if (overflow)   n_ovf++;
         if (rx_valid && rx_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: got %02h, required no pop", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (rx_data !== mon_exp) begin
                  n_fail++;
                  $display("FAIL pop_data: got %02h, required %02h", rx_data, mon_exp);
               end
            end
         end
      end
   end

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_cmp++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   // rp: pulse rx_ready for the single cycle in which this bit's fall pushes the byte.
   task automatic send_bit(input logic b, input bit rp);
      ps2_data_in = b;
      wait_cycles(HALF);
      ps2_clk_in    = 1'b0;
      last_fall_cyc = cyc;
      if (rp) begin
         repeat (5) @(posedge clk);
         #1 rx_ready = 1'b1;
         @(posedge clk);
         #1 rx_ready = 1'b0;
         wait_cycles(HALF - 6);
      end else begin
         wait_cycles(HALF);
      end
      ps2_clk_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input bit rp);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
      send_bit(par, 1'b0);
      send_bit(stop, rp);
      ps2_data_in = 1'b1;
      wait_cycles(HALF);
   endtask

   task automatic glitch();
      @(posedge clk);
      #1 ps2_clk_in = 1'b0;
      repeat (FILTER - 1) @(posedge clk);
      #1 ps2_clk_in = 1'b1;
      wait_cycles(10);
   endtask

   task automatic drain(input string name);
      rx_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) wait_cycles(1);
      wait_cycles(1);
      rx_ready = 1'b0;
      wait_cycles(2);
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_valid"}, rx_valid, 0);
      check({name, "_data0"}, rx_data, 0);
   endtask

   task automatic test_reset();
      wait_cycles(5);
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_pulses", {parity_err, frame_err, overflow}, 0);
      reset_n = 1'b1;
      wait_cycles(5);
      check("rst_busy_after", busy, 0);
   endtask

   task automatic test_basic();
      int p0, f0, o0;
      p0 = n_par; f0 = n_frm; o0 = n_ovf;
      exp_q.push_back(8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
      check("basic_valid", rx_valid, 1);
      check("basic_data", rx_data, 8'h1C);
      check("basic_errs", (n_par - p0) + (n_frm - f0) + (n_ovf - o0), 0);
      rx_ready = 1'b1;
      wait_cycles(1);
      rx_ready = 1'b0;
      wait_cycles(1);
      check("basic_pop_valid", rx_valid, 0);
      check("basic_pop_data", rx_data, 0);
      check("basic_pop_left", exp_q.size(), 0);
   endtask

   task automatic test_parity_err();
      int p0, f0;
      p0 = n_par; f0 = n_frm;
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      check("par_pulses", n_par - p0, 1);
      check("par_no_frame", n_frm - f0, 0);
      check("par_valid", rx_valid, 0);
   endtask

   task automatic test_frame_err();
      int p0, f0;
      p0 = n_par; f0 = n_frm;
      send_frame(8'h55, ~odd_par(8'h55), 1'b0, 1'b0);
      check("frm_pulses", n_frm - f0, 1);
      check("frm_no_parity", n_par - p0, 0);
      check("frm_valid", rx_valid, 0);
   endtask

   task automatic test_timeout();
      int f0, dt;
      f0 = n_frm;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
      check("tmo_busy_mid", busy, 1);
      for (int i = 0; i < 2 * TMO && n_frm == f0; i++) wait_cycles(1);
      dt = cyc - last_fall_cyc;
      check("tmo_pulse", n_frm - f0, 1);
      n_cmp++;
      if (dt < int'(TMO) || dt > int'(TMO) + 12) begin
         n_fail++;
         $display("FAIL tmo_latency: got %0d cycles, required %0d..%0d", dt, TMO, TMO + 12);
      end
      check("tmo_busy_after", busy, 0);
      rx_ready = 1'b1;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
      rx_ready = 1'b0;
      check("tmo_next_left", exp_q.size(), 0);
      check("tmo_next_one_err", n_frm - f0, 1);
   endtask

   task automatic test_overflow();
      int o0;
      o0 = n_ovf;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) exp_q.push_back(8'(i));
         send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
      end
      check("ovf_pulse", n_ovf - o0, 1);
      check("ovf_head", rx_data, 8'h01);
      drain("ovf_drain");
      o0 = n_ovf;
      for (int i = 8'h11; i <= 8'h18; i++) begin
         exp_q.push_back(8'(i));
         send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
      end
      exp_q.push_back(8'h19);
      send_frame(8'h19, odd_par(8'h19), 1'b1, 1'b1);
      check("ovf_simul_none", n_ovf - o0, 0);
      drain("ovf_simul_drain");
   endtask

   task automatic test_glitch();
      int p0, f0;
      p0 = n_par; f0 = n_frm;
      glitch();
      check("glitch_idle_busy", busy, 0);
      rx_ready = 1'b1;
      exp_q.push_back(8'hA7);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(i == 0 || i == 1 || i == 2 || i == 5 || i == 7, 1'b0);
         if (i == 3) glitch();
      end
      send_bit(odd_par(8'hA7), 1'b0);
      send_bit(1'b1, 1'b0);
      wait_cycles(HALF);
      rx_ready = 1'b0;
      check("glitch_left", exp_q.size(), 0);
      check("glitch_errs", (n_par - p0) + (n_frm - f0), 0);
   endtask

   task automatic test_reset_midframe();
      exp_q.push_back(8'h42);
      send_frame(8'h42, odd_par(8'h42), 1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      check("mid_busy", busy, 1);
      check("mid_valid", rx_valid, 1);
      reset_n = 1'b0;
      exp_q.delete();
      #2;
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_data", rx_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pulses", {parity_err, frame_err, overflow}, 0);
      ps2_data_in = 1'b1;
      wait_cycles(5);
      reset_n = 1'b1;
      wait_cycles(5);
      rx_ready = 1'b1;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, odd_par(8'h3C), 1'b1, 1'b0);
      rx_ready = 1'b0;
      check("mid_next_left", exp_q.size(), 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_err();
      test_frame_err();
      test_timeout();
      test_overflow();
      test_glitch();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
